// File: rtl/stream_pkg.sv
// Shared token format for the VecAdd result stream: 32-bit payload plus an end-of-transaction flag.
`timescale 1ns/1ps
package stream_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TOKEN_W = 33;
    localparam int unsigned EOT_BIT = 32;

    typedef struct packed {
        logic              eot;
        logic [DATA_W-1:0] data;
    } token_t;

    function automatic logic is_eot(input token_t t);
        return t.eot;
    endfunction

endpackage

// File: rtl/stream_fifo_core.sv
// First-word-fall-through storage: register array, wrapping pointers, occupancy and registered full_n/empty_n/dout.
`timescale 1ns/1ps
module stream_fifo_core #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_req,
    input  logic             rd_req,
    output logic [WIDTH-1:0] dout,
    output logic             full_n,
    output logic             empty_n,
    output logic             rd_acc_c
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W  = ADDR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_ptr_nxt;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  occ_nxt;
    logic              wr_acc_c;

    assign wr_acc_c   = wr_req && full_n;
    assign rd_acc_c   = rd_req && empty_n;
    assign rd_ptr_nxt = rd_ptr + ADDR_W'(1);

    always_comb begin
        occ_nxt = occ;
        if (wr_acc_c && !rd_acc_c) begin
            occ_nxt = occ + OCC_W'(1);
        end else if (!wr_acc_c && rd_acc_c) begin
            occ_nxt = occ - OCC_W'(1);
        end
    end

    // Storage has no reset; entries are only ever read after being written.
    always_ff @(posedge ap_clk) begin
        if (wr_acc_c) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            full_n  <= 1'b1;
            empty_n <= 1'b0;
            dout    <= '0;
        end else begin
            occ     <= occ_nxt;
            full_n  <= (occ_nxt != FULL_OCC);
            empty_n <= (occ_nxt != '0);
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc_c) begin
                rd_ptr <= rd_ptr_nxt;
            end
            // Head register tracks mem[rd_ptr]; the new head may be the word being written this edge.
            if (rd_acc_c) begin
                dout <= (wr_acc_c && (wr_ptr == rd_ptr_nxt)) ? din : mem[rd_ptr_nxt];
            end else if (wr_acc_c && !empty_n) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/stream_eot_fifo.sv
// Result-stream FIFO behind VecAdd c_s: buffers tokens, counts per-transaction lengths, flags handshake violations.
`timescale 1ns/1ps
module stream_eot_fifo
    import stream_pkg::*;
#(
    parameter int unsigned WIDTH = TOKEN_W,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [WIDTH-1:0] c_s_din,
    input  logic             c_s_write,
    output logic             c_s_full_n,
    output logic [WIDTH-1:0] out_dout,
    output logic             out_empty_n,
    input  logic             out_read,
    output logic [CNT_W-1:0] elem_count,
    output logic [CNT_W-1:0] last_len,
    output logic [CNT_W-1:0] txn_count,
    output logic             overflow,
    output logic             underflow
);

    logic rd_acc_c;
    logic head_eot_c;

    stream_fifo_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .din      (c_s_din),
        .wr_req   (c_s_write),
        .rd_req   (out_read),
        .dout     (out_dout),
        .full_n   (c_s_full_n),
        .empty_n  (out_empty_n),
        .rd_acc_c (rd_acc_c)
    );

    assign head_eot_c = out_dout[WIDTH-1];

    // Close tokens end a transaction and are not counted as data.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            elem_count <= '0;
            last_len   <= '0;
            txn_count  <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (rd_acc_c) begin
                if (head_eot_c) begin
                    last_len   <= elem_count;
                    elem_count <= '0;
                    txn_count  <= txn_count + CNT_W'(1);
                end else begin
                    elem_count <= elem_count + CNT_W'(1);
                end
            end
            if (c_s_write && !c_s_full_n) begin
                overflow <= 1'b1;
            end
            if (out_read && !out_empty_n) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_eot_fifo.sv
// Directed plus randomized bench for stream_eot_fifo against a queue-based transaction model.
`timescale 1ns/1ps
module tb_stream_eot_fifo;
    import stream_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b1;
    logic [32:0] c_s_din = '0;
    logic        c_s_write = 1'b0;
    logic        c_s_full_n;
    logic [32:0] out_dout;
    logic        out_empty_n;
    logic        out_read = 1'b0;
    logic [31:0] elem_count;
    logic [31:0] last_len;
    logic [31:0] txn_count;
    logic        overflow;
    logic        underflow;

    int errors = 0;
    int checks = 0;

    logic [32:0] q [$];
    logic [31:0] m_elem;
    logic [31:0] m_last;
    logic [31:0] m_txn;
    logic        m_ovf;
    logic        m_unf;

    stream_eot_fifo #(.WIDTH(33), .DEPTH(DEPTH), .CNT_W(32)) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .c_s_din     (c_s_din),
        .c_s_write   (c_s_write),
        .c_s_full_n  (c_s_full_n),
        .out_dout    (out_dout),
        .out_empty_n (out_empty_n),
        .out_read    (out_read),
        .elem_count  (elem_count),
        .last_len    (last_len),
        .txn_count   (txn_count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".empty_n"}, 64'(out_empty_n), 64'(q.size() != 0));
        chk({tag, ".full_n"}, 64'(c_s_full_n), 64'(q.size() != DEPTH));
        if (q.size() != 0) chk({tag, ".dout"}, 64'(out_dout), 64'(q[0]));
        chk({tag, ".elem_count"}, 64'(elem_count), 64'(m_elem));
        chk({tag, ".last_len"}, 64'(last_len), 64'(m_last));
        chk({tag, ".txn_count"}, 64'(txn_count), 64'(m_txn));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        chk({tag, ".underflow"}, 64'(underflow), 64'(m_unf));
    endtask

    // One clock of traffic; the model applies the transaction rules to its pre-edge view.
    task automatic step(input string tag, input logic wr, input logic [32:0] d, input logic rd);
        int          sz;
        logic [32:0] tok;
        c_s_write = wr;
        c_s_din   = d;
        out_read  = rd;
        @(posedge ap_clk);
        sz = q.size();
        if (wr && sz == DEPTH) m_ovf = 1'b1;
        if (rd && sz == 0) m_unf = 1'b1;
        if (rd && sz != 0) begin
            tok = q.pop_front();
            if (is_eot(token_t'(tok))) begin
                m_last = m_elem;
                m_elem = 0;
                m_txn  = m_txn + 1;
            end else begin
                m_elem = m_elem + 1;
            end
        end
        if (wr && sz != DEPTH) q.push_back(d);
        #1;
        c_s_write = 1'b0;
        out_read  = 1'b0;
        check_all(tag);
    endtask

    // Reset is asserted mid-cycle; outputs must clear before the next clock edge.
    task automatic do_reset(input string tag);
        #2;
        ap_rst_n  = 1'b0;
        c_s_write = 1'b0;
        out_read  = 1'b0;
        q.delete();
        m_elem = 0; m_last = 0; m_txn = 0; m_ovf = 1'b0; m_unf = 1'b0;
        #1;
        chk({tag, ".rst_dout"}, 64'(out_dout), 64'h0);
        check_all({tag, ".rst"});
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    initial begin
        logic [32:0] t1 [6];
        logic [31:0] txn_before;
        logic [32:0] d;

        // 1: five floats and a close token, then drain
        t1[0] = 33'h0_3F80_0000; t1[1] = 33'h0_4040_0000; t1[2] = 33'h0_40A0_0000;
        t1[3] = 33'h0_40E0_0000; t1[4] = 33'h0_4110_0000; t1[5] = 33'h1_0000_0000;
        do_reset("t1");
        for (int i = 0; i < 6; i++) step("t1.wr", 1'b1, t1[i], 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("t1.seq", 64'(out_dout), 64'(t1[i]));
            step("t1.rd", 1'b0, '0, 1'b1);
        end
        chk("t1.last_len5", 64'(last_len), 64'd5);
        chk("t1.txn1", 64'(txn_count), 64'd1);
        chk("t1.elem0", 64'(elem_count), 64'd0);

        // 2: fill, overflow, one pop frees space
        do_reset("t2");
        for (int i = 0; i < 16; i++) step("t2.wr", 1'b1, 33'(i + 'h100), 1'b0);
        chk("t2.full", 64'(c_s_full_n), 64'd0);
        step("t2.ovf", 1'b1, 33'h0_DEAD_BEEF, 1'b0);
        chk("t2.ovf_flag", 64'(overflow), 64'd1);
        chk("t2.head", 64'(out_dout), 64'h100);
        step("t2.pop", 1'b0, '0, 1'b1);
        chk("t2.not_full", 64'(c_s_full_n), 64'd1);

        // 3: underflow, then simultaneous write+read on empty
        do_reset("t3");
        step("t3.unf", 1'b0, '0, 1'b1);
        chk("t3.unf_flag", 64'(underflow), 64'd1);
        chk("t3.still_empty", 64'(out_empty_n), 64'd0);
        step("t3.wr_rd", 1'b1, 33'h0_0000_0055, 1'b1);
        chk("t3.nonempty", 64'(out_empty_n), 64'd1);
        chk("t3.dout", 64'(out_dout), 64'h55);
        step("t3.drain", 1'b0, '0, 1'b1);
        chk("t3.occ1_drained", 64'(out_empty_n), 64'd0);

        // 4: streaming write+read for 40 tokens, pointers wrap
        do_reset("t4");
        step("t4.prime", 1'b1, 33'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) begin
            d = {($urandom_range(0, 3) == 0), 32'($urandom)};
            step("t4.stream", 1'b1, d, 1'b1);
            chk("t4.occ1", 64'(out_empty_n && c_s_full_n), 64'd1);
        end
        chk("t4.no_ovf", 64'(overflow), 64'd0);
        chk("t4.no_unf", 64'(underflow), 64'd0);

        // 5: back-to-back close tokens
        step("t5.drain", 1'b0, '0, 1'b1);
        step("t5.data", 1'b1, 33'h0_1234_5678, 1'b0);
        step("t5.close", 1'b1, 33'h1_0000_0000, 1'b0);
        step("t5.close", 1'b1, 33'h1_0000_0000, 1'b0);
        step("t5.rd", 1'b0, '0, 1'b1);
        txn_before = txn_count;
        step("t5.rd", 1'b0, '0, 1'b1);
        step("t5.rd", 1'b0, '0, 1'b1);
        chk("t5.last_len0", 64'(last_len), 64'd0);
        chk("t5.txn_plus2", 64'(txn_count), 64'(txn_before + 32'd2));

        // 6: mid-clock reset with 7 buffered and a partial count of 3
        do_reset("t6");
        for (int i = 0; i < 10; i++) step("t6.wr", 1'b1, 33'(i + 1), 1'b0);
        for (int i = 0; i < 3; i++) step("t6.rd", 1'b0, '0, 1'b1);
        chk("t6.elem3", 64'(elem_count), 64'd3);
        do_reset("t6.mid");
        step("t6.after_wr", 1'b1, 33'h0_0000_00AA, 1'b0);
        step("t6.after_wr", 1'b1, 33'h1_0000_0000, 1'b0);
        step("t6.after_rd", 1'b0, '0, 1'b1);
        step("t6.after_rd", 1'b0, '0, 1'b1);
        chk("t6.after_len", 64'(last_len), 64'd1);

        // Randomized traffic including occasional protocol violations
        do_reset("rnd");
        for (int i = 0; i < 400; i++) begin
            d = {($urandom_range(0, 4) == 0), 32'($urandom)};
            step("rnd", ($urandom_range(0, 9) < 6), d, ($urandom_range(0, 9) < 5));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
